// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs 32-bit words into 128-bit AES key/ciphertext blocks with credit gating
// Optional: PACKER_ZERO_PAD_EN issues s_last-closed partial blocks zero-padded instead of dropping them.
module aes_block_packer #(
    parameter int CREDITS = 16,
    parameter int CW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_key,
    input  logic          s_last,
    output logic [127:0]  blk_data,
    output logic          blk_valid,
    output logic [127:0]  key_data,
    output logic          key_valid,
    input  logic          credit_ret,
    output logic [CW-1:0] credits,
    output logic          err,
    output logic [1:0]    err_code
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    state_t        state;
    logic [1:0]    word_cnt;
    logic          blk_type;
    logic [127:0]  pack_buf;
    logic [127:0]  buf_next;

    logic xfer, cur_type, mix, done, partial, issue_ok;
    logic key_issue, data_ready, data_go, to_hold, hold_go, issue_data, overflow;

    assign xfer     = s_valid && s_ready;
    assign cur_type = (word_cnt == 2'd0) ? s_key : blk_type;
    assign mix      = xfer && (word_cnt != 2'd0) && (s_key != blk_type);
    assign done     = xfer && ((word_cnt == 2'd3) || s_last);
    assign partial  = xfer && s_last && (word_cnt != 2'd3);

`ifdef PACKER_ZERO_PAD_EN
    assign issue_ok = done;
`else
    assign issue_ok = done && !partial;
`endif

    assign key_issue  = issue_ok && cur_type;
    assign data_ready = issue_ok && !cur_type;
    // A return arriving with the last word pays for the block even at zero credits.
    assign data_go    = data_ready && ((credits != '0) || credit_ret);
    assign to_hold    = data_ready && !data_go;
    assign hold_go    = (state == HOLD) && credit_ret;
    assign issue_data = data_go || hold_go;
    assign overflow   = credit_ret && !issue_data && (credits == CRED_MAX);

    // Word 0 starts from zero so a short block is already padded in its low words.
    always_comb begin
        buf_next = (word_cnt == 2'd0) ? 128'd0 : pack_buf;
        case (word_cnt)
            2'd0:    buf_next[127:96] = s_data;
            2'd1:    buf_next[95:64]  = s_data;
            2'd2:    buf_next[63:32]  = s_data;
            default: buf_next[31:0]   = s_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            s_ready   <= 1'b1;
            word_cnt  <= 2'd0;
            blk_type  <= 1'b0;
            pack_buf  <= '0;
            blk_data  <= '0;
            blk_valid <= 1'b0;
            key_data  <= '0;
            key_valid <= 1'b0;
            credits   <= CRED_MAX;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            blk_valid <= 1'b0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            if (xfer) begin
                pack_buf <= buf_next;
                word_cnt <= done ? 2'd0 : word_cnt + 2'd1;
                if (word_cnt == 2'd0)
                    blk_type <= s_key;
            end
            if (key_issue) begin
                key_data  <= buf_next;
                key_valid <= 1'b1;
            end
            if (data_go) begin
                blk_data  <= buf_next;
                blk_valid <= 1'b1;
            end
            if (hold_go) begin
                blk_data  <= pack_buf;
                blk_valid <= 1'b1;
                state     <= COLLECT;
                s_ready   <= 1'b1;
            end
            if (to_hold) begin
                state   <= HOLD;
                s_ready <= 1'b0;
            end
            if (issue_data && !credit_ret)
                credits <= credits - 1'b1;
            else if (credit_ret && !issue_data && !overflow)
                credits <= credits + 1'b1;
            if (overflow || mix || partial) begin
                err      <= 1'b1;
                err_code <= overflow ? 2'd3 : (mix ? 2'd2 : 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - randomized and directed checks of aes_block_packer against a block-level model
module tb_aes_block_packer;

    localparam int CREDITS = 16;
    localparam int CW      = 5;
`ifdef PACKER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_key = 1'b0;
    logic          s_last = 1'b0;
    logic [127:0]  blk_data;
    logic          blk_valid;
    logic [127:0]  key_data;
    logic          key_valid;
    logic          credit_ret = 1'b0;
    logic [CW-1:0] credits;
    logic          err;
    logic [1:0]    err_code;

    aes_block_packer #(.CREDITS(CREDITS), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_key(s_key), .s_last(s_last), .blk_data(blk_data), .blk_valid(blk_valid),
        .key_data(key_data), .key_valid(key_valid), .credit_ret(credit_ret),
        .credits(credits), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words of the open block, credit count, a parked block when out of credits.
    logic [31:0]  m_q[$];
    logic         m_type;
    int           m_credits;
    bit           m_hold;
    logic [127:0] m_pend;
    logic [127:0] e_blk_data, e_key_data;
    logic         e_blk_valid, e_key_valid, e_err;
    logic [1:0]   e_err_code;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_type      = 1'b0;
        m_credits   = CREDITS;
        m_hold      = 1'b0;
        m_pend      = '0;
        e_blk_data  = '0;
        e_key_data  = '0;
        e_blk_valid = 1'b0;
        e_key_valid = 1'b0;
        e_err       = 1'b0;
        e_err_code  = 2'd0;
    endtask

    task automatic compare_all();
        check_eq("blk_valid", 128'(blk_valid), 128'(e_blk_valid));
        check_eq("blk_data",  blk_data, e_blk_data);
        check_eq("key_valid", 128'(key_valid), 128'(e_key_valid));
        check_eq("key_data",  key_data, e_key_data);
        check_eq("credits",   128'(credits), 128'(m_credits));
        check_eq("err",       128'(err), 128'(e_err));
        check_eq("err_code",  128'(err_code), 128'(e_err_code));
        check_eq("s_ready",   128'(s_ready), 128'(!m_hold));
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model, compare at the next negedge.
    task automatic step(input logic v, input logic k, input logic l, input logic r, input logic [31:0] d);
        logic [127:0] blk;
        int code;
        bit issue_data;
        bit full;
        s_valid = v; s_key = k; s_last = l; credit_ret = r; s_data = d;
        code = 0;
        issue_data = 1'b0;
        e_blk_valid = 1'b0;
        e_key_valid = 1'b0;
        if (m_hold) begin
            if (r) begin
                e_blk_valid = 1'b1;
                e_blk_data  = m_pend;
                m_hold      = 1'b0;
                issue_data  = 1'b1;
            end
        end else if (v) begin
            if (m_q.size() == 0) m_type = k;
            else if (k != m_type) code = 2;
            m_q.push_back(d);
            if (m_q.size() == 4 || l) begin
                full = (m_q.size() == 4);
                if (!full && code < 1) code = 1;
                blk = '0;
                foreach (m_q[i]) blk[127-32*i -: 32] = m_q[i];
                if (full || PAD) begin
                    if (m_type) begin
                        e_key_valid = 1'b1;
                        e_key_data  = blk;
                    end else if (m_credits > 0 || r) begin
                        e_blk_valid = 1'b1;
                        e_blk_data  = blk;
                        issue_data  = 1'b1;
                    end else begin
                        m_hold = 1'b1;
                        m_pend = blk;
                    end
                end
                m_q.delete();
            end
        end
        m_credits = m_credits + (r ? 1 : 0) - (issue_data ? 1 : 0);
        if (m_credits > CREDITS) begin
            m_credits = CREDITS;
            code = 3;
        end
        e_err = (code != 0);
        if (e_err) e_err_code = 2'(code);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, 1'b0, r, 32'd0);
    endtask

    task automatic blk4(input logic k, input logic [127:0] b, input logic r_last);
        for (int i = 0; i < 4; i++)
            step(1'b1, k, 1'b0, (i == 3) ? r_last : 1'b0, b[127-32*i -: 32]);
    endtask

    task automatic do_reset();
        s_valid = 1'b0; s_last = 1'b0; credit_ret = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_blk_valid", 128'(blk_valid), 128'd0);
        check_eq("rst_credits", 128'(credits), 128'(CREDITS));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    logic [127:0] rb;
    logic         rtype, kbit, vbit, lbit, rbit;
    int           ret_pct;

    initial begin
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("reset_s_ready", 128'(s_ready), 128'd1);
        rst = 1'b0;
        compare_all();

        // Key load
        blk4(1'b1, 128'h2B7E151628AED2A6ABF7158809CF4F3C, 1'b0);
        check_eq("key_strobe", 128'(key_valid), 128'd1);
        check_eq("key_value", key_data, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
        check_eq("key_credits", 128'(credits), 128'd16);

        // Two back-to-back data blocks
        for (int b = 0; b < 2; b++) begin
            rb = {$urandom, $urandom, $urandom, $urandom};
            blk4(1'b0, rb, 1'b0);
            check_eq("stream_strobe", 128'(blk_valid), 128'd1);
            check_eq("stream_data", blk_data, rb);
            check_eq("stream_ready", 128'(s_ready), 128'd1);
        end
        check_eq("stream_credits", 128'(credits), 128'd14);

        // Down to one credit, then a return alongside the 4th word
        for (int b = 0; b < 13; b++) blk4(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        check_eq("one_credit", 128'(credits), 128'd1);
        blk4(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        check_eq("simul_strobe", 128'(blk_valid), 128'd1);
        check_eq("simul_credits", 128'(credits), 128'd1);

        // Refill and overflow
        for (int i = 0; i < 15; i++) idle(1'b1);
        check_eq("full_credits", 128'(credits), 128'd16);
        idle(1'b1);
        check_eq("ovf_err", 128'(err), 128'd1);
        check_eq("ovf_code", 128'(err_code), 128'd3);
        check_eq("ovf_credits", 128'(credits), 128'd16);

        // Exhaustion and HOLD
        for (int b = 0; b < 16; b++) blk4(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        check_eq("empty_credits", 128'(credits), 128'd0);
        rb = {$urandom, $urandom, $urandom, $urandom};
        blk4(1'b0, rb, 1'b0);
        check_eq("hold_no_strobe", 128'(blk_valid), 128'd0);
        check_eq("hold_ready", 128'(s_ready), 128'd0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check_eq("hold_ready_still", 128'(s_ready), 128'd0);
        idle(1'b1);
        check_eq("hold_release", 128'(blk_valid), 128'd1);
        check_eq("hold_data", blk_data, rb);
        check_eq("hold_credits", 128'(credits), 128'd0);

        // Reset mid-block
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
        do_reset();
        check_eq("post_rst_credits", 128'(credits), 128'd16);
        idle(1'b0);
        check_eq("post_rst_quiet", 128'(blk_valid), 128'd0);
        rb = 128'h00112233445566778899AABBCCDDEEFF;
        blk4(1'b0, rb, 1'b0);
        check_eq("post_rst_block", blk_data, rb);

        // Partial block closed by s_last
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h11111111);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h22222222);
        check_eq("partial_code", 128'(err_code), 128'd1);
        check_eq("partial_strobe", 128'(blk_valid), 128'(PAD));
        if (PAD) check_eq("partial_data", blk_data, 128'h11111111222222220000000000000000);
        check_eq("partial_credits", 128'(credits), PAD ? 128'd14 : 128'd15);

        // Randomized traffic against the model
        rtype = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            ret_pct = (c < 1500) ? 4 : 30;
            if (m_q.size() == 0) rtype = ($urandom_range(0, 9) < 3);
            kbit = ($urandom_range(0, 99) < 3) ? !rtype : rtype;
            vbit = ($urandom_range(0, 99) < 70);
            lbit = ($urandom_range(0, 99) < 5);
            rbit = ($urandom_range(0, 99) < ret_pct);
            step(vbit, kbit, lbit, rbit, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
- Upstream feeder for the AES-128 decryption pipeline.
- Accepts a 32-bit word stream over a valid/ready handshake and assembles 4 words into one 128-bit block.
- Each completed block is issued as either a one-cycle cipher-key load (key_data/key_valid) or a one-cycle ciphertext block (blk_data/blk_valid).
- Ciphertext issue is credit-gated so the decrypter's input FIFO can never overflow.

Parameters:
- CREDITS, 16: initial/maximum credits; equals decrypter input FIFO depth in blocks.
- CW, 5: credit counter width; must satisfy CREDITS ≤ 2^CW−1.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_data  in  32  input word
- s_valid  in  1  word valid
- s_ready  out  1  packer can accept word
- s_key  in  1  word belongs to key block; sampled on the first word of each block
- s_last  in  1  last word of a message
- blk_data  out  128  ciphertext block; drives decrypter data_in
- blk_valid  out  1  one-cycle block strobe; drives decrypter valid_in
- key_data  out  128  cipher key; drives decrypter key
- key_valid  out  1  one-cycle key strobe; drives decrypter valid_key
- credit_ret  in  1  one pulse per block drained from decrypter input FIFO
- credits  out  CW  current available credits
- err  out  1  one-cycle error strobe
- err_code  out  2  1 = partial block, 2 = key/data mix, 3 = credit overflow; held until the next err

Behaviour:
- Reset (async): state = COLLECT, word_cnt = 0, credits = CREDITS. All strobes = 0; blk_data, key_data, err_code = 0.
- Handshake: a word transfers when s_valid && s_ready. s_ready = 1 in COLLECT, 0 in HOLD. s_ready is a registered/state decode; no combinational path from s_valid.
- Packing:
  - Word n (0..3) goes to buf[127−32n −: 32]; first word is MSW (AES byte order).
  - word_cnt increments per transfer and wraps 3→0.
  - blk_type latches s_key on word 0.
  - If s_key differs from blk_type on words 1–3: err pulse, err_code = 2; the word is still packed per blk_type.
- Completion (4th word accepted at cycle T):
  - Key block: key_data = buf, key_valid = 1 at T+1. Consumes no credit.
  - Data block with credits > 0, or credit_ret at T: blk_data = buf, blk_valid = 1 at T+1, credits −1 (net 0 if credit_ret at T). State stays COLLECT, so back-to-back blocks every 4 cycles.
  - Data block with credits == 0 and no credit_ret: enter HOLD, s_ready = 0.
- HOLD: on the first cycle with credit_ret = 1, issue the block the next cycle, credits unchanged (return cancels consume), return to COLLECT.
- s_last:
  - Accepted on word_cnt = 3: normal completion.
  - Accepted on word_cnt < 3: partial block, handled per the optional feature.
  - word_cnt returns to 0 either way.
- Credits:
  - +1 per credit_ret, −1 per data block issued; simultaneous events net to 0.
  - credit_ret when credits == CREDITS and no issue: count saturates, err pulse, err_code = 3.
- blk_data/key_data hold their value after the strobe until the next issue.
- rst asserted mid-block or in HOLD discards the buffered words and the pending block; no strobe follows reset.

Optional Feature:
- Macro: PACKER_ZERO_PAD_EN.
- Defined: a partial block closed by s_last is zero-padded in the unfilled low words and issued like a full block of its type (credit rules apply). err pulses with err_code = 1 as information.
- Undefined: the partial block is discarded, no strobe, no credit consumed. err pulses with err_code = 1.

Test Plan:
- Key load: s_key = 1, words 0x2B7E1516, 0x28AED2A6, 0xABF71588, 0x09CF4F3C → key_valid one cycle after 4th word, key_data = 0x2B7E151628AED2A6ABF7158809CF4F3C, credits stays 16.
- Data stream: 8 words s_key = 0 continuous valid → blk_valid at cycles 4 and 8 after first word; credits 16→14; s_ready constantly 1.
- Credit exhaustion: CREDITS = 2, 3 data blocks, no credit_ret → 2 strobes, then HOLD with s_ready = 0. Pulse credit_ret → 3rd blk_valid the next cycle, credits = 0.
- Simultaneous: credit_ret in the same cycle as a 4th-word accept with credits = 1 → block issued, credits stays 1. credit_ret at credits = 16 → err = 1, err_code = 3, credits = 16.
- Partial: words 0x11111111, 0x22222222 with s_last on the 2nd →
  - with PACKER_ZERO_PAD_EN: blk_data = 0x11111111222222220000000000000000, err_code = 1.
  - without: no blk_valid, err_code = 1, credits unchanged.
- Reset mid-block: 2 words accepted, pulse rst → no strobe. Next 4 words form a clean block with first word at MSW; credits = 16 after reset.
